// File: rtl/bist_controller_multi.sv
// Multi-channel BIST sequencer: IDLE/INIT/RUN/FINISH/DONE session
// with LFSR stimulus, sticky per-channel fail map and abort.
module bist_controller_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  parameter int INIT_CYCLES = 4,
  parameter int PAT_W = 16,
  parameter logic [PAT_W-1:0] TAPS = 16'hB400,
  parameter logic [PAT_W-1:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic [CNT_W-1:0]  run_len,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic [NUM_CH-1:0] chan_fail,
  output logic              mode,
  output logic              init,
  output logic              running,
  output logic              finish,
  output logic              bist_end,
  output logic [PAT_W-1:0]  pattern,
  output logic [NUM_CH-1:0] fail_map,
  output logic              pass,
  output logic              aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  len_q;
  logic [NUM_CH-1:0] en_q;
  logic [PAT_W-1:0]  pat_q;
  logic [NUM_CH-1:0] fail_q;
  logic              abort_q;
  logic              mode_q;
  logic              init_q;
  logic              run_q;
  logic              fin_q;
  logic              end_q;
  logic              pass_q;

  function automatic logic [PAT_W-1:0] lfsr_next(
    input logic [PAT_W-1:0] p
  );
    return (p >> 1) ^ (p[0] ? TAPS : '0);
  endfunction

  // Session FSM; every output is a register updated with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      en_q    <= '0;
      pat_q   <= SEED;
      fail_q  <= '0;
      abort_q <= 1'b0;
      mode_q  <= 1'b0;
      init_q  <= 1'b0;
      run_q   <= 1'b0;
      fin_q   <= 1'b0;
      end_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bist_start) begin
            state_q <= S_INIT;
            len_q   <= run_len;
            en_q    <= chan_en;
            fail_q  <= '0;
            abort_q <= 1'b0;
            cnt_q   <= INIT_LD;
            pat_q   <= SEED;
            mode_q  <= 1'b1;
            init_q  <= 1'b1;
          end
        end
        S_INIT: begin
          if (bist_abort || cnt_q == '0) begin
            init_q <= 1'b0;
            if (!bist_abort && len_q != '0) begin
              state_q <= S_RUN;
              cnt_q   <= len_q - ONE;
              run_q   <= 1'b1;
            end else begin
              state_q <= S_FIN;
              cnt_q   <= '0;
              fin_q   <= 1'b1;
              abort_q <= bist_abort;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_RUN: begin
          pat_q  <= lfsr_next(pat_q);
          fail_q <= fail_q | (chan_fail & en_q);
          if (bist_abort || cnt_q == '0) begin
            state_q <= S_FIN;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            fin_q   <= 1'b1;
            abort_q <= bist_abort;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_FIN: begin
          state_q <= S_DONE;
          fin_q   <= 1'b0;
          mode_q  <= 1'b0;
          end_q   <= 1'b1;
          pass_q  <= (fail_q == '0) && !abort_q;
        end
        S_DONE: begin
          if (!bist_start) begin
            state_q <= S_IDLE;
            end_q   <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          mode_q  <= 1'b0;
          init_q  <= 1'b0;
          run_q   <= 1'b0;
          fin_q   <= 1'b0;
          end_q   <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mode     = mode_q;
  assign init     = init_q;
  assign running  = run_q;
  assign finish   = fin_q;
  assign bist_end = end_q;
  assign pattern  = pat_q;
  assign fail_map = fail_q;
  assign pass     = pass_q;
  assign aborted  = abort_q;

endmodule

// File: doc/bist_controller_multi.md
Name: bist_controller_multi

Overview:
Parametrised, multi-channel successor to the single-channel BIST sequencer. It runs a BIST session IDLE -> INIT -> RUN -> FINISH -> DONE, with a programmable run length, a per-channel enable mask and an abort input. It generates an LFSR stimulus pattern, accumulates per-channel compare failures into a sticky fail map, and reports pass/fail. It sits between the test-mode top level and NUM_CH memory/datapath channels under test.

Parameters:
NUM_CH, 4, number of channels under test (>=1)
CNT_W, 8, width of run_len and of the internal cycle counter
INIT_CYCLES, 4, cycles spent in INIT (1..2^CNT_W-1)
PAT_W, 16, LFSR pattern width
TAPS, 16'hB400, Galois LFSR tap mask (PAT_W bits)
SEED, 16'hACE1, LFSR load value in INIT; must be nonzero

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
bist_start  in  1  level request; sampled only in IDLE
bist_abort  in  1  abort request; effective in INIT/RUN only
run_len  in  CNT_W  RUN duration in cycles; latched on start
chan_en  in  NUM_CH  channel enable mask; latched on start
chan_fail  in  NUM_CH  per-channel compare-fail strobe; sampled in RUN only
mode  out  1  1 = BIST owns the datapath (INIT, RUN, FINISH)
init  out  1  1 in INIT
running  out  1  1 in RUN
finish  out  1  1 in FINISH
bist_end  out  1  1 in DONE
pattern  out  PAT_W  current LFSR stimulus
fail_map  out  NUM_CH  sticky per-channel failure bits
pass  out  1  valid while bist_end=1
aborted  out  1  sticky; session ended by abort

Behaviour:
- All outputs are registered and state-decoded (Moore). There is no combinational path from input to output.
- Reset (reset=0, async assert, sync release): state=IDLE, counter=0, pattern=SEED, fail_map=0, pass=0, aborted=0, and mode/init/running/finish/bist_end=0.
- IDLE: if bist_start=1 at the edge, then at that edge latch run_len and chan_en, clear fail_map and aborted, and go to INIT. Otherwise stay.
- INIT: lasts exactly INIT_CYCLES cycles. pattern is held at SEED. Next state is RUN, or FINISH if latched run_len=0.
- RUN: lasts exactly latched run_len cycles.
  - pattern advances once per RUN cycle: next = (pattern>>1) ^ (pattern[0] ? TAPS : 0).
  - fail_map <= fail_map | (chan_fail & latched chan_en) each RUN cycle.
  - After the last RUN cycle, go to FINISH.
- FINISH: lasts exactly 1 cycle. pattern holds; fail_map holds. Next state is DONE.
- DONE: bist_end=1 and pass = (fail_map==0) && !aborted. pass, fail_map and aborted hold. Go to IDLE when bist_start=0 at an edge, so a held-high start never retriggers.
- In IDLE, outputs pass and fail_map keep their last values until the next start clears fail_map. pass drops to 0 on leaving DONE.
- Abort: bist_abort=1 at an edge in INIT or RUN sets aborted=1 and moves to FINISH.
  - Abort coincident with the last RUN or INIT cycle: abort wins, aborted=1.
  - chan_fail in that same RUN cycle is still accumulated.
  - Abort in IDLE, FINISH or DONE is ignored.
- bist_start changes outside IDLE are ignored. run_len and chan_en changes after latch have no effect.
- Latched chan_en=0: the session runs normally, fail_map stays 0, and pass=1 unless aborted.
- Timing (INIT_CYCLES=4, run_len=N, start seen at edge 0):
  - init=1 in cycles 1..4
  - running=1 in cycles 5..4+N
  - finish=1 in cycle 5+N
  - bist_end=1 from cycle 6+N
- Reset asserted mid-session returns to IDLE immediately with reset values. There is no resume.
- The counter is CNT_W bits wide, loads per state and counts down. It never wraps within a state.

Test Plan:
- Reset, then bist_start=1 held, run_len=10, chan_en=4'hF, chan_fail=0 -> init cycles 1-4, running 5-14, finish 15, bist_end=1 pass=1 fail_map=0 from 16. With bist_start still high, no restart occurs.
- Same session, check pattern: INIT shows 16'hACE1; RUN cycles show 16'hE270 at cycle 6 (after the first advance), then 16'h7138. pattern at FINISH equals the value after 10 advances.
- chan_en=4'b0101, pulse chan_fail=4'b0011 in RUN cycle 3 -> fail_map=4'b0001, pass=0 at bist_end.
- bist_abort=1 in RUN cycle 2 of run_len=10 -> finish next cycle, aborted=1, pass=0. Abort pulsed in DONE -> no change.
- run_len=0 -> INIT (4 cycles) then FINISH directly, running never 1, pass=1. Drop bist_start -> IDLE; raise again -> new session with fail_map cleared.
- reset=0 asserted mid-RUN between clock edges -> all outputs 0 and pattern=16'hACE1 immediately. After release with start held, a new session begins.
